matrix_reader: RTL and testbench

//  Read side of the matrix BRAM store; reads back what the matrix writer stores.

---
 rtl/matrix_reader.sv | 216 +++++++++++++++++++++
 tb/tb_matrix_reader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matrix_reader                                                 |
// | Purpose  : Read side of the matrix BRAM store. Fetches a stored matrix   |
// |            slot: a 3-word header (rows/cols, 8-byte name), then streams  |
// |            the row-major elements on a valid/ready interface through a   |
// |            2-entry output FIFO (1 element/clk when data_ready is high).  |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            read_request/matrix_id/reader_ready : request side            |
// |            actual_rows/actual_cols/matrix_name/meta_valid/read_error     |
// |                                                : header results          |
// |            data_out/data_valid/data_ready/data_last/read_done            |
// |                                                : element stream          |
// |            bram_rd_en/bram_addr/bram_dout     : BRAM read port (1 clk)   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module matrix_reader #(
    parameter int BLOCK_SIZE = 1152,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_request,
    input  logic [2:0]            matrix_id,
    output logic                  reader_ready,
    output logic [7:0]            actual_rows,
    output logic [7:0]            actual_cols,
    output logic [0:7][7:0]       matrix_name,
    output logic                  meta_valid,
    output logic                  read_error,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  data_last,
    output logic                  read_done,
    output logic                  bram_rd_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_hdr0     = 3'd1;
    localparam logic [2:0] c_hdr1     = 3'd2;
    localparam logic [2:0] c_hdr2     = 3'd3;
    localparam logic [2:0] c_hdr_wait = 3'd4;
    localparam logic [2:0] c_stream   = 3'd5;
    localparam logic [2:0] c_done     = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] c_block     = ADDR_WIDTH'(BLOCK_SIZE);
    localparam logic [15:0]           c_max_elems = 16'(BLOCK_SIZE - 3);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [7:0]            r_hdr_rows;
    logic [7:0]            r_hdr_cols;
    logic [31:0]           r_name_hi;
    logic [15:0]           r_num;
    logic                  r_skip;
    logic [15:0]           r_idx;
    logic [15:0]           r_pop_idx;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_fifo [0:1];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_last_pop;
    logic [2:0]            w_occ;
    logic [15:0]           w_num;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_elem_addr;

    assign w_base      = ADDR_WIDTH'(matrix_id) * c_block;
    assign w_elem_addr = r_base + ADDR_WIDTH'(r_idx) + ADDR_WIDTH'(3);
    assign w_num       = {8'd0, r_hdr_rows} * {8'd0, r_hdr_cols};

    assign data_valid   = (r_count != 2'd0);
    assign data_out     = r_fifo[r_rd_ptr];
    assign data_last    = data_valid && (r_pop_idx == (r_num - 16'd1));
    assign reader_ready = (r_state == c_idle);
    assign read_done    = (r_state == c_done);

    assign w_pop      = data_valid && data_ready;
    assign w_push     = r_inflight;
    assign w_last_pop = w_pop && (r_pop_idx == (r_num - 16'd1));

    // Slots already committed (buffered + returning) after this cycle's pop;
    // issuing only while this is below 2 guarantees a returning word always
    // has a FIFO entry to land in, so no BRAM read is ever dropped.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == c_stream) && !r_skip &&
                     (r_idx < r_num) && (w_occ < 3'd2);

    always_comb begin
        w_next_state = r_state;
        bram_rd_en   = 1'b0;
        bram_addr    = '0;
        case (r_state)
            c_idle: begin
                if (read_request) w_next_state = c_hdr0;
            end
            c_hdr0: begin
                bram_rd_en   = 1'b1;
                bram_addr    = r_base;
                w_next_state = c_hdr1;
            end
            c_hdr1: begin
                bram_rd_en   = 1'b1;
                bram_addr    = r_base + ADDR_WIDTH'(1);
                w_next_state = c_hdr2;
            end
            c_hdr2: begin
                bram_rd_en   = 1'b1;
                bram_addr    = r_base + ADDR_WIDTH'(2);
                w_next_state = c_hdr_wait;
            end
            c_hdr_wait: begin
                w_next_state = c_stream;
            end
            c_stream: begin
                bram_rd_en = w_issue;
                if (w_issue) bram_addr = w_elem_addr;
                // Empty or oversized matrices leave without touching the data.
                if (r_skip || w_last_pop) w_next_state = c_done;
            end
            c_done: begin
                w_next_state = c_idle;
            end
            default: begin
                w_next_state = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_base      <= '0;
            r_hdr_rows  <= '0;
            r_hdr_cols  <= '0;
            r_name_hi   <= '0;
            r_num       <= '0;
            r_skip      <= 1'b0;
            r_idx       <= '0;
            r_pop_idx   <= '0;
            r_inflight  <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= '0;
            actual_rows <= '0;
            actual_cols <= '0;
            matrix_name <= '0;
            meta_valid  <= 1'b0;
            read_error  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            meta_valid <= 1'b0;
            read_error <= 1'b0;

            case (r_state)
                c_idle: begin
                    if (read_request) begin
                        r_base    <= w_base;
                        r_idx     <= '0;
                        r_pop_idx <= '0;
                        r_skip    <= 1'b0;
                        r_wr_ptr  <= 1'b0;
                        r_rd_ptr  <= 1'b0;
                        r_count   <= '0;
                    end
                end
                c_hdr1: begin
                    r_hdr_rows <= bram_dout[31:24];
                    r_hdr_cols <= bram_dout[23:16];
                end
                c_hdr2: begin
                    r_name_hi <= bram_dout[31:0];
                end
                c_hdr_wait: begin
                    // All header outputs change together with the meta pulse.
                    actual_rows <= r_hdr_rows;
                    actual_cols <= r_hdr_cols;
                    matrix_name <= {r_name_hi, bram_dout[31:0]};
                    r_num       <= w_num;
                    r_skip      <= (w_num == 16'd0) || (w_num > c_max_elems);
                    meta_valid  <= 1'b1;
                    read_error  <= (w_num > c_max_elems);
                end
                default: begin
                end
            endcase

            // Element pipeline; all terms are idle outside the stream phase.
            r_inflight <= w_issue;
            if (w_issue) r_idx <= r_idx + 16'd1;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= bram_dout;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr  <= ~r_rd_ptr;
                r_pop_idx <= r_pop_idx + 16'd1;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_matrix_reader                                              |
// | Purpose  : Scoreboard bench for matrix_reader with a 1-clk BRAM model.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_matrix_reader;

    localparam int BLOCK_SIZE = 1152;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 14;

    logic                  clk;
    logic                  rst_n;
    logic                  read_request;
    logic [2:0]            matrix_id;
    logic                  reader_ready;
    logic [7:0]            actual_rows;
    logic [7:0]            actual_cols;
    logic [0:7][7:0]       matrix_name;
    logic                  meta_valid;
    logic                  read_error;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  data_last;
    logic                  read_done;
    logic                  bram_rd_en;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_dout;

    matrix_reader #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_request (read_request),
        .matrix_id    (matrix_id),
        .reader_ready (reader_ready),
        .actual_rows  (actual_rows),
        .actual_cols  (actual_cols),
        .matrix_name  (matrix_name),
        .meta_valid   (meta_valid),
        .read_error   (read_error),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_last    (data_last),
        .read_done    (read_done),
        .bram_rd_en   (bram_rd_en),
        .bram_addr    (bram_addr),
        .bram_dout    (bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: data valid one clock after the enabled read.
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (bram_rd_en) bram_dout <= mem[bram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] exp_q  [$];   // {last, data}
    logic [80:0] meta_q [$];   // {err, rows, cols, name}

    int rdy_mode = 0;          // 0: ready high, 1: random, 2: ready low
    int cur_base = 0;
    int meta_cyc, done_cyc, done_cnt, data_cnt;
    int first_pop_cyc, last_pop_cyc, issue_cyc, issue_cnt;
    int addr_min, addr_max;
    bit          prev_stall = 1'b0;
    logic [32:0] prev_data  = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic fail_event(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: actual event seen, required none", nm);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents something.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (meta_valid) begin
                meta_cyc = cyc;
                if (meta_q.size() == 0) fail_event("unexpected_meta");
                else begin
                    logic [80:0] m;
                    m = meta_q.pop_front();
                    check("meta_rows", 64'(actual_rows), 64'(m[79:72]));
                    check("meta_cols", 64'(actual_cols), 64'(m[71:64]));
                    check("meta_name", matrix_name, m[63:0]);
                    check("meta_err",  64'(read_error), 64'(m[80]));
                end
            end
            if (bram_rd_en) begin
                issue_cnt++;
                if (int'(bram_addr) < addr_min) addr_min = int'(bram_addr);
                if (int'(bram_addr) > addr_max) addr_max = int'(bram_addr);
                if (issue_cyc < 0 && int'(bram_addr) == cur_base + 3) issue_cyc = cyc;
            end
            if (prev_stall)
                check("stall_stable", {30'd0, data_valid, data_last, data_out}, {31'd1, prev_data});
            if (data_valid && data_ready) begin
                if (data_cnt == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                data_cnt++;
                if (exp_q.size() == 0) fail_event("unexpected_data");
                else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("elem_data", 64'(data_out), 64'(e[31:0]));
                    check("elem_last", 64'(data_last), 64'(e[32]));
                end
            end
            prev_stall = data_valid && !data_ready;
            prev_data  = {data_last, data_out};
            if (read_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        data_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       data_ready = 1'b1;
                1:       data_ready = 1'($urandom_range(0, 1));
                default: data_ready = 1'b0;
            endcase
        end
    end

    task automatic load(input int slot, input logic [7:0] rows, input logic [7:0] cols,
                        input logic [63:0] name, input logic [31:0] dbase);
        int b;
        int n;
        b = slot * BLOCK_SIZE;
        n = int'(rows) * int'(cols);
        if (n > BLOCK_SIZE - 3) n = BLOCK_SIZE - 3;
        mem[b]     = {rows, cols, 16'h0000};
        mem[b + 1] = name[63:32];
        mem[b + 2] = name[31:0];
        for (int i = 0; i < n; i++) mem[b + 3 + i] = dbase + 32'(i);
    endtask

    task automatic clear_stats(input int slot);
        cur_base = slot * BLOCK_SIZE;
        meta_cyc = -1; done_cyc = -1; done_cnt = 0; data_cnt = 0;
        first_pop_cyc = -1; last_pop_cyc = -1; issue_cyc = -1; issue_cnt = 0;
        addr_min = 1 << 20; addr_max = -1;
    endtask

    task automatic start_read(input int slot, output int t);
        @(posedge clk);
        #1;
        read_request = 1'b1;
        matrix_id    = 3'(slot);
        t            = cyc;
        @(posedge clk);
        #1;
        read_request = 1'b0;
        matrix_id    = ~3'(slot);   // must be ignored after acceptance
    endtask

    task automatic expect_matrix(input logic [7:0] rows, input logic [7:0] cols,
                                 input logic [63:0] name, input logic [31:0] dbase, input bit err);
        int n;
        n = int'(rows) * int'(cols);
        meta_q.push_back({err, rows, cols, name});
        if (!err)
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), dbase + 32'(i)});
    endtask

    task automatic do_read(input int slot, input logic [7:0] rows, input logic [7:0] cols,
                           input logic [63:0] name, input logic [31:0] dbase,
                           input bit err, input int mode, input string tag);
        int t;
        int n;
        n = err ? 0 : int'(rows) * int'(cols);
        expect_matrix(rows, cols, name, dbase, err);
        rdy_mode = mode;
        start_read(slot, t);
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(posedge clk);
        if (done_cnt == 0) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: actual no read_done, required read_done", tag);
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_meta_cyc"}, 64'(meta_cyc - t), 64'd5);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_elem_cnt"}, 64'(data_cnt), 64'(n));
        check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_ready"},    64'(reader_ready), 64'd1);
        if (n == 0) check({tag, "_done_cyc"}, 64'(done_cyc - t), 64'd6);
    endtask

    localparam logic [63:0] c_name_a = "MATA0001";
    localparam logic [63:0] c_name_b = "MATB0016";
    localparam logic [63:0] c_name_z = "ZERO0000";
    localparam logic [63:0] c_name_e = "BIG40X40";

    initial begin
        int t;
        for (int i = 0; i < 16384; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        rst_n = 1'b0; read_request = 1'b0; matrix_id = 3'd0;
        load(1, 8'd2, 8'd3, c_name_a, 32'd1);
        load(2, 8'd4, 8'd4, c_name_b, 32'hA000_0000);
        load(3, 8'd40, 8'd40, c_name_e, 32'hE000_0000);
        load(4, 8'd0, 8'd5, c_name_z, 32'h5000_0000);
        #3;
        check("rst_ready", 64'(reader_ready), 64'd1);
        check("rst_outs", {meta_valid, read_error, data_valid, data_last, read_done, bram_rd_en},
              64'd0);
        check("rst_hdr", {actual_rows, actual_cols, 48'd0}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 2x3 matrix in slot 1, random back-pressure, address range check.
        clear_stats(1);
        do_read(1, 8'd2, 8'd3, c_name_a, 32'd1, 1'b0, 1, "m2x3");
        check("m2x3_addr_min", 64'(addr_min), 64'd1152);
        check("m2x3_addr_max", 64'(addr_max), 64'd1160);
        check("m2x3_issues",   64'(issue_cnt), 64'd9);

        // Same matrix at full throughput.
        clear_stats(1);
        do_read(1, 8'd2, 8'd3, c_name_a, 32'd1, 1'b0, 0, "full");
        check("full_back2back", 64'(last_pop_cyc - first_pop_cyc), 64'd5);
        check("full_stream_len", 64'(last_pop_cyc - issue_cyc), 64'd7);

        // 4x4 with random ready and a spurious request mid-stream.
        clear_stats(2);
        fork
            do_read(2, 8'd4, 8'd4, c_name_b, 32'hA000_0000, 1'b0, 1, "m4x4");
            begin
                for (int k = 0; k < 300 && data_cnt < 3; k++) @(posedge clk);
                #1 read_request = 1'b1; matrix_id = 3'd1;
                @(posedge clk);
                #1 read_request = 1'b0;
            end
        join

        // Zero rows: header only, no error.
        clear_stats(4);
        do_read(4, 8'd0, 8'd5, c_name_z, 32'h0, 1'b0, 0, "zero");

        // 40x40 exceeds the slot: error, no data.
        clear_stats(3);
        do_read(3, 8'd40, 8'd40, c_name_e, 32'h0, 1'b1, 0, "big");

        // Reset while the stream is stalled.
        clear_stats(2);
        expect_matrix(8'd4, 8'd4, c_name_b, 32'hA000_0000, 1'b0);
        rdy_mode = 2;
        start_read(2, t);
        for (int k = 0; k < 100 && !data_valid; k++) @(posedge clk);
        check("rst_mid_valid_seen", 64'(data_valid), 64'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 64'(reader_ready), 64'd1);
        check("rst_mid_outs", {meta_valid, read_error, data_valid, data_last, read_done, bram_rd_en},
              64'd0);
        check("rst_mid_hdr", {actual_rows, actual_cols, 48'd0}, 64'd0);
        check("rst_mid_name", matrix_name, 64'd0);
        check("rst_mid_data", 64'(data_out), 64'd0);
        check("rst_mid_addr", 64'(bram_addr), 64'd0);
        exp_q.delete();
        meta_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // New request after reset and after a completed read.
        clear_stats(2);
        do_read(2, 8'd4, 8'd4, c_name_b, 32'hA000_0000, 1'b0, 1, "again");
        clear_stats(1);
        do_read(1, 8'd2, 8'd3, c_name_a, 32'd1, 1'b0, 0, "after");

        check("meta_q_empty", 64'(meta_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
